semaforo_ctrl: RTL and testbench
================================

# semaforo_ctrl

Sequential traffic-light controller for the board's signal display. It cycles PARE → SIGA → ATENÇÃO → PARE on programmable cycle counts. A latched pedestrian request shortens SIGA, and a maintenance mode blinks ATENÇÃO. Outputs are one-hot by construction, so the inconsistency indication (seg[7]) is never produced. It sits between the switch inputs and the 7-segment driver: SWI bits feed manut/ped_req, and seg drives SEG.

## Interface
- T_PARE, 8: cycles spent in PARE
- T_SIGA, 6: nominal cycles in SIGA
- T_SIGA_MIN, 3: minimum SIGA cycles before a pedestrian request may cut it (1 ≤ T_SIGA_MIN ≤ T_SIGA)
- T_ATENCAO, 2: cycles in ATENÇÃO
- T_PISCA, 2: half-period of the maintenance blink, in cycles
- TW, 4: timer width; every duration is ≤ 2^TW

Ports:
- clk_2 input 1: clock. One clock; reset is asynchronous and active-high.
- reset input 1: async active-high reset
- manut input 1: maintenance mode (level)
- ped_req input 1: pedestrian request (sampled each cycle, level or pulse)
- pare output 1: red
- atencao output 1: yellow
- siga output 1: green
- seg output 8: display pattern
- restante output TW: current timer value (cycles left − 1)
- ped_ack output 1: one-cycle pulse when a pending request is served

## Operation
- States: PARE, SIGA, ATENCAO, MANUT.
- Each state has a down-counter `timer`.
  - On entry, `timer` loads DUR−1 and decrements every cycle.
  - When timer==0, the state transitions at the next edge, so each state lasts exactly DUR cycles.
- Transitions:
  - PARE → SIGA
  - SIGA → ATENCAO
  - ATENCAO → PARE
- Pedestrian pending flag `ped_pend`:
  - Set when ped_req=1 in SIGA or ATENCAO.
  - ped_req is ignored in PARE and MANUT.
- Early exit from SIGA: if ped_pend=1 and timer ≤ T_SIGA−T_SIGA_MIN, go to ATENCAO at the next edge. SIGA therefore never lasts fewer than T_SIGA_MIN cycles.
- Entering PARE from ATENCAO with ped_pend=1:
  - ped_pend clears.
  - ped_ack=1 for the first PARE cycle only.
- Maintenance has priority over every other rule:
  - manut=1 sampled in any state → MANUT at the next edge. timer loads T_PISCA−1, ped_pend clears, blink flag is set to 1.
  - In MANUT, when timer==0, blink toggles and timer reloads.
  - manut=0 sampled in MANUT → PARE at the next edge with the full T_PARE. No ped_ack is issued.
- Output decode (combinational from the state/blink registers):
  - PARE: pare=1, seg=8'b01110011
  - SIGA: siga=1, seg=8'b01101101
  - ATENCAO: atencao=1, seg=8'b01110111
  - MANUT: atencao=blink, seg=blink ? 8'b01110111 : 8'b00000000
  - All other lamp outputs are 0. seg[7] is always 0.
- Reset values: state=PARE, timer=T_PARE−1, ped_pend=0, blink=0, ped_ack=0, pare=1, atencao=0, siga=0, seg=8'b01110011, restante=T_PARE−1.

## Timing
- All registers update on the rising edge of clk_2. Outputs reflect the new state immediately after that edge.
- No input-to-output combinational path exists.
- Latency:
  - ped_req → ped_pend visible: 1 cycle.
  - manut → MANUT: 1 cycle.
- ped_req in the same cycle as SIGA→ATENCAO: it is latched, and it is served at the following PARE entry.
- ped_req and manut in the same cycle: manut wins; the request is discarded.
- Reset asserted mid-cycle forces the reset values asynchronously. The first state after release is PARE with its full duration.
- Full cycle period without requests: T_PARE+T_SIGA+T_ATENCAO = 16 cycles.

## Structure
- Package `semaforo_pkg` holds:
  - `typedef enum logic [1:0] {PARE, SIGA, ATENCAO, MANUT} estado_t`
  - the SEG constants SEG_P, SEG_A, SEG_S, SEG_OFF
- Sub-module `temporizador` (TW-bit loadable down-counter):
  - inputs: load, load_val, en
  - output: zero
- The FSM, ped_pend, blink and output decode live in semaforo_ctrl.

## Test plan
- Reset, then release with no requests (defaults): pare for 8 cycles, siga for 6, atencao for 2, then pare again. Period is 16 cycles; ped_ack is never 1.
- ped_req pulse in the first SIGA cycle: SIGA lasts 3 cycles, ATENCAO lasts 2, then PARE with ped_ack=1 for exactly its first cycle. The following SIGA returns to 6 cycles.
- ped_req held high through all of PARE only: no pend is set, SIGA lasts 6 cycles, no ped_ack.
- manut=1 during SIGA: MANUT from the next cycle. seg alternates 8'b01110111 for 2 cycles and 8'b00000000 for 2 cycles. After manut=0, PARE for 8 cycles with no ped_ack.
- reset asserted asynchronously mid-ATENCAO with ped_pend=1: pare=1 and seg=8'b01110011 at once, ped_pend=0. After release, PARE lasts 8 cycles.

Source files
------------

// File: rtl/semaforo_pkg.sv
// Shared types and display patterns for the traffic-light controller.
package semaforo_pkg;

    typedef enum logic [1:0] {
        PARE    = 2'd0,
        SIGA    = 2'd1,
        ATENCAO = 2'd2,
        MANUT   = 2'd3
    } estado_t;

    // 7-segment patterns; bit 7 is the inconsistency indication and stays 0.
    localparam logic [7:0] SEG_P   = 8'b0111_0011;
    localparam logic [7:0] SEG_S   = 8'b0110_1101;
    localparam logic [7:0] SEG_A   = 8'b0111_0111;
    localparam logic [7:0] SEG_OFF = 8'b0000_0000;

endpackage

// File: rtl/semaforo_ctrl_temporizador.sv
// Loadable down-counter that parks at zero; zero flags the last cycle of a state.
module temporizador #(
    parameter int            TW      = 4,
    parameter logic [TW-1:0] RST_VAL = '0
) (
    input  logic          clk_2,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    output logic [TW-1:0] valor,
    output logic          zero
);

    // Load has priority over counting; counting stops at zero.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            valor <= RST_VAL;
        end else if (load) begin
            valor <= load_val;
        end else if (en && (valor != '0)) begin
            valor <= valor - TW'(1);
        end
    end

    assign zero = (valor == '0);

endmodule

// File: rtl/semaforo_ctrl.sv
// Traffic-light sequencer: PARE -> SIGA -> ATENCAO -> PARE with pedestrian
// shortening of SIGA and a blinking maintenance mode.
//
// state   | meaning
// --------+----------------------------------------------------------
// PARE    | red, T_PARE cycles
// SIGA    | green, T_SIGA cycles, cut to >= T_SIGA_MIN by a pending request
// ATENCAO | yellow, T_ATENCAO cycles
// MANUT   | maintenance, yellow blinking with half-period T_PISCA
module semaforo_ctrl
    import semaforo_pkg::*;
#(
    parameter int T_PARE     = 8,
    parameter int T_SIGA     = 6,
    parameter int T_SIGA_MIN = 3,
    parameter int T_ATENCAO  = 2,
    parameter int T_PISCA    = 2,
    parameter int TW         = 4
) (
    input  logic          clk_2,
    input  logic          reset,
    input  logic          manut,
    input  logic          ped_req,
    output logic          pare,
    output logic          atencao,
    output logic          siga,
    output logic [7:0]    seg,
    output logic [TW-1:0] restante,
    output logic          ped_ack
);

    // A pending request may end SIGA once this many cycles or fewer remain (minus one).
    localparam logic [TW-1:0] LIM_SIGA = TW'(T_SIGA - T_SIGA_MIN);

    estado_t       estado, estado_nx;
    logic          ped_pend;
    logic          blink;
    logic          load;
    logic [TW-1:0] load_val;
    logic [TW-1:0] timer;
    logic          timer_zero;
    logic          serve;

    temporizador #(
        .TW      (TW),
        .RST_VAL (TW'(T_PARE - 1))
    ) u_tmr (
        .clk_2    (clk_2),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (1'b1),
        .valor    (timer),
        .zero     (timer_zero)
    );

    // Next state and timer reload; maintenance overrides every other transition.
    always_comb begin
        estado_nx = estado;
        load_val  = TW'(T_PARE - 1);
        case (estado)
            PARE:    if (timer_zero) estado_nx = SIGA;
            SIGA:    if (timer_zero || (ped_pend && (timer <= LIM_SIGA))) estado_nx = ATENCAO;
            ATENCAO: if (timer_zero) estado_nx = PARE;
            MANUT:   if (!manut) estado_nx = PARE;
            default: estado_nx = PARE;
        endcase
        if (manut) estado_nx = MANUT;

        load = (estado_nx != estado) || ((estado == MANUT) && timer_zero);
        case (estado_nx)
            PARE:    load_val = TW'(T_PARE - 1);
            SIGA:    load_val = TW'(T_SIGA - 1);
            ATENCAO: load_val = TW'(T_ATENCAO - 1);
            MANUT:   load_val = TW'(T_PISCA - 1);
            default: load_val = TW'(T_PARE - 1);
        endcase
    end

    assign serve = (estado == ATENCAO) && (estado_nx == PARE) && ped_pend;

    // State register plus request latch, acknowledge pulse and blink phase.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            estado   <= PARE;
            ped_pend <= 1'b0;
            blink    <= 1'b0;
            ped_ack  <= 1'b0;
        end else begin
            estado  <= estado_nx;
            ped_ack <= serve;

            if (manut) begin
                ped_pend <= 1'b0;
            end else if (serve) begin
                ped_pend <= 1'b0;
            end else if (((estado == SIGA) || (estado == ATENCAO)) && ped_req) begin
                ped_pend <= 1'b1;
            end

            if ((estado != MANUT) && (estado_nx == MANUT)) begin
                blink <= 1'b1;
            end else if ((estado == MANUT) && timer_zero) begin
                blink <= ~blink;
            end
        end
    end

    // Lamp and display decode from registered state only.
    always_comb begin
        pare    = 1'b0;
        atencao = 1'b0;
        siga    = 1'b0;
        seg     = SEG_OFF;
        case (estado)
            PARE:    begin pare = 1'b1;    seg = SEG_P; end
            SIGA:    begin siga = 1'b1;    seg = SEG_S; end
            ATENCAO: begin atencao = 1'b1; seg = SEG_A; end
            MANUT:   begin atencao = blink; seg = blink ? SEG_A : SEG_OFF; end
            default: begin pare = 1'b0;    seg = SEG_OFF; end
        endcase
    end

    assign restante = timer;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Self-checking bench for semaforo_ctrl: segment table drives inputs and
// queues per-cycle expectations; a negedge checker pops and compares.
module tb_semaforo_ctrl;

    logic       clk_2;
    logic       reset;
    logic       manut;
    logic       ped_req;
    logic       pare, atencao, siga, ped_ack;
    logic [7:0] seg;
    logic [3:0] restante;

    semaforo_ctrl dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .manut    (manut),
        .ped_req  (ped_req),
        .pare     (pare),
        .atencao  (atencao),
        .siga     (siga),
        .seg      (seg),
        .restante (restante),
        .ped_ack  (ped_ack)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    // segment kinds
    localparam int K_P    = 0;
    localparam int K_S    = 1;
    localparam int K_A    = 2;
    localparam int K_MON  = 3;
    localparam int K_MOFF = 4;

    typedef struct {
        logic manut;
        logic ped;
        int   n;
        int   kind;
        int   r0;
        logic ack;
    } rec_t;

    typedef struct packed {
        logic [2:0] lamps;   // {pare, atencao, siga}
        logic [7:0] seg;
        logic [3:0] rest;
        logic       ack;
    } obs_t;

    rec_t tab[64];
    int   n_rec = 0;
    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cyc = 0;

    function automatic obs_t exp_of(int kind, int rest, logic ack);
        obs_t o;
        o.rest = 4'(rest);
        o.ack  = ack;
        case (kind)
            K_P:     begin o.lamps = 3'b100; o.seg = 8'b01110011; end
            K_S:     begin o.lamps = 3'b001; o.seg = 8'b01101101; end
            K_A:     begin o.lamps = 3'b010; o.seg = 8'b01110111; end
            K_MON:   begin o.lamps = 3'b010; o.seg = 8'b01110111; end
            default: begin o.lamps = 3'b000; o.seg = 8'b00000000; end
        endcase
        return o;
    endfunction

    function automatic obs_t actual();
        obs_t o;
        o.lamps = {pare, atencao, siga};
        o.seg   = seg;
        o.rest  = restante;
        o.ack   = ped_ack;
        return o;
    endfunction

    task automatic check(string nm, obs_t act, obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got lamps=%b seg=%b rest=%0d ack=%b, expected lamps=%b seg=%b rest=%0d ack=%b",
                     nm, act.lamps, act.seg, act.rest, act.ack,
                     exp.lamps, exp.seg, exp.rest, exp.ack);
        end
    endtask

    task automatic add(logic m, logic p, int n, int kind, int r0, logic ack);
        tab[n_rec] = '{manut: m, ped: p, n: n, kind: kind, r0: r0, ack: ack};
        n_rec++;
    endtask

    // Drive inputs at each negedge and queue that cycle's expected outputs.
    task automatic run(int lo, int hi);
        for (int r = lo; r < hi; r++) begin
            for (int i = 0; i < tab[r].n; i++) begin
                manut   = tab[r].manut;
                ped_req = tab[r].ped;
                exp_q.push_back(exp_of(tab[r].kind, tab[r].r0 - i, tab[r].ack && (i == 0)));
                @(negedge clk_2);
            end
        end
        manut   = 1'b0;
        ped_req = 1'b0;
    endtask

    task automatic drain();
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d queued, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Scoreboard side: compare the oldest expectation against this cycle's outputs.
    always @(negedge clk_2) begin
        obs_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("cyc%0d", n_cyc), actual(), e);
            n_cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int f_end;

        // defaults, two full periods
        add(0,0,8,K_P,7,0); add(0,0,6,K_S,5,0); add(0,0,2,K_A,1,0);
        add(0,0,8,K_P,7,0); add(0,0,6,K_S,5,0); add(0,0,2,K_A,1,0);
        // pedestrian pulse in first SIGA cycle
        add(0,0,8,K_P,7,0); add(0,1,1,K_S,5,0); add(0,0,2,K_S,4,0); add(0,0,2,K_A,1,0);
        add(0,0,1,K_P,7,1); add(0,0,7,K_P,6,0); add(0,0,6,K_S,5,0); add(0,0,2,K_A,1,0);
        // request held through PARE is ignored
        add(0,1,8,K_P,7,0); add(0,0,6,K_S,5,0); add(0,0,2,K_A,1,0);
        // maintenance from SIGA, concurrent request discarded
        add(0,0,8,K_P,7,0); add(0,0,2,K_S,5,0); add(1,1,1,K_S,3,0);
        add(1,1,2,K_MON,1,0); add(1,1,2,K_MOFF,1,0); add(0,1,1,K_MON,1,0);
        add(0,0,8,K_P,7,0); add(0,0,6,K_S,5,0); add(0,0,2,K_A,1,0);
        // request on last SIGA cycle, then on last ATENCAO cycle with nothing pending
        add(0,0,1,K_P,7,0); add(0,0,7,K_P,6,0); add(0,0,5,K_S,5,0); add(0,1,1,K_S,0,0);
        add(0,0,2,K_A,1,0); add(0,0,1,K_P,7,1); add(0,0,7,K_P,6,0); add(0,0,6,K_S,5,0);
        add(0,0,1,K_A,1,0); add(0,1,1,K_A,0,0); add(0,0,8,K_P,7,0); add(0,0,3,K_S,5,0);
        add(0,0,2,K_A,1,0); add(0,0,1,K_P,7,1); add(0,0,7,K_P,6,0);
        // reach mid-ATENCAO with a pending request
        add(0,1,1,K_S,5,0); add(0,0,2,K_S,4,0); add(0,0,1,K_A,1,0);
        f_end = n_rec;
        // after async reset: full PARE, full SIGA, no acknowledge
        add(0,0,8,K_P,7,0); add(0,0,6,K_S,5,0); add(0,0,2,K_A,1,0); add(0,0,1,K_P,7,0);

        reset   = 1'b1;
        manut   = 1'b0;
        ped_req = 1'b0;
        @(negedge clk_2);
        #2;
        check("reset_state", actual(), exp_of(K_P, 7, 1'b0));
        @(negedge clk_2);
        reset = 1'b0;

        run(0, f_end);
        drain();

        #1;
        reset = 1'b1;
        #1;
        check("async_reset", actual(), exp_of(K_P, 7, 1'b0));
        @(negedge clk_2);
        reset = 1'b0;

        run(f_end, n_rec);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
